iru_coord_gen: RTL and testbench
================================

IRU_COORD_GEN -- requirements
Module: iru_coord_gen

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low; released synchronously to clk.
REQ-003 SHALL have port start, input, 1 bit: request one 20x20 rotation sweep; sampled only in IDLE.
REQ-004 SHALL have port angle, input, 36 bits: one-hot angle; bit 35 = 0 deg, each lower bit +10 deg.
REQ-005 SHALL have port sin_d, output, 36 bits: one-hot index to the sine LUT.
REQ-006 SHALL have port cos_d, output, 36 bits: one-hot index to the second sine LUT instance, used as cosine.
REQ-007 SHALL have port sin_q / cos_q, input, 9 bits each: signed Q1.7 LUT results; 128 = +1.0.
REQ-008 SHALL have port out_valid, output, 1 bit: coordinate beat valid.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts beat.
REQ-010 SHALL have port out_src_x / out_src_y, output, 6 bits each: signed source column/row.
REQ-011 SHALL have port out_inb, output, 1 bit: both source coords in 0..19.
REQ-012 SHALL have port out_last, output, 1 bit: beat is pixel (19,19).
REQ-013 SHALL have port busy, output, 1 bit: high in any state except IDLE.
REQ-014 SHALL have port angle_err, output, 1 bit: one-cycle pulse on start with non-one-hot angle.

Function
REQ-015 SHALL implement states IDLE, LOAD, RUN, with transitions:
- IDLE -> LOAD on start with one-hot angle; angle latched into ang_r.
- LOAD -> RUN after exactly one cycle; sin_q/cos_q registered into s_r/c_r.
- RUN -> IDLE on the handshake of the out_last beat.
REQ-016 SHALL drive sin_d = ang_r and cos_d = {ang_r[8:0], ang_r[35:9]} (+90 deg); both 0 in IDLE.
REQ-017 SHALL, on start with angle not exactly one-hot, pulse angle_err for one cycle, stay IDLE, and leave ang_r unchanged.
REQ-018 SHALL ignore start while busy.
REQ-019 SHALL step row r 0..19 (outer) and column c 0..19 (inner), raster order, 400 beats per sweep.
REQ-020 SHALL use xc = c-10 and yc = r-10.
REQ-021 SHALL compute in 13-bit signed arithmetic:
- src_x = ((xc*c_r - yc*s_r) >>> 7) + 10
- src_y = ((xc*s_r + yc*c_r) >>> 7) + 10
- >>> is arithmetic shift (floor); no rounding or saturation.
- Result range -10..30 truncated losslessly to 6-bit signed.
REQ-022 SHALL set out_inb = 1 when 0 <= src_x <= 19 and 0 <= src_y <= 19, else 0.
REQ-023 SHALL hold out_src_x, out_src_y, out_inb and out_last in registers.
REQ-024 SHALL load the output registers in RUN when (!out_valid || out_ready) and unissued pixels remain; out_valid then 1.
REQ-025 SHALL clear out_valid when out_ready is high and nothing remains to issue.
REQ-026 SHALL hold out_valid and all out_* stable while out_valid && !out_ready.
REQ-027 SHALL advance the counters only when a beat is loaded; with out_ready held at 1, one beat per cycle, no gaps.
REQ-028 SHALL meet this latency: start sampled at edge N -> LOAD at N, RUN at N+1, first out_valid=1 after edge N+2.

Reset
REQ-029 SHALL, while rst_n = 0, force:
- state IDLE; ang_r, s_r, c_r, r, c = 0.
- out_valid, out_src_x, out_src_y, out_inb, out_last, busy, angle_err = 0.
REQ-030 SHALL abandon a sweep when reset is asserted mid-sweep; no further beats after release until a new start.

Verification
REQ-031 SHALL cover: angle bit35 (0 deg), out_ready = 1 -> 400 beats, each src = (c, r), out_inb = 1, out_last only on beat 400, busy low one cycle after it.
REQ-032 SHALL cover: angle bit26 (90 deg) -> beat 0 src_x = 20, src_y = 0, out_inb = 0; beat 21 (r=1, c=1) src_x = 19, src_y = 1, out_inb = 1.
REQ-033 SHALL cover: angle bit34 (10 deg, s=22, c=126) -> beat 0 src_x = 1, src_y = -2, out_inb = 0 (checks floor shift).
REQ-034 SHALL cover: random out_ready toggling -> no beat lost, duplicated or changed while stalled; 400 handshakes exactly.
REQ-035 SHALL cover: start with angle = 0 or two bits set -> angle_err pulses once, busy stays 0, no beats.
REQ-036 SHALL cover: rst_n low at beat 150, then new start at 180 deg -> first beat src_x = 20, src_y = 20, out_inb = 0, count restarts at 400.

Source files
------------

// File: rtl/iru_coord_gen_if.sv
// Coordinate beat stream from the rotation coordinate generator to its consumer.
// The master drives the beat and the slave drives the ready.
interface iru_coord_gen_if;
   logic              out_valid;
   logic              out_ready;
   logic signed [5:0] out_src_x;
   logic signed [5:0] out_src_y;
   logic              out_inb;
   logic              out_last;

   modport master (
      output out_valid, out_src_x, out_src_y, out_inb, out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_src_x, out_src_y, out_inb, out_last,
      output out_ready
   );
endinterface

// File: rtl/iru_coord_gen.sv
// Inverse-rotation source coordinate generator for a 20x20 tile: for each
// destination pixel in raster order it emits the rotated source pixel.
module iru_coord_gen (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [35:0]          angle,
   output logic [35:0]          sin_d,
   output logic [35:0]          cos_d,
   input  logic signed [8:0]    sin_q,
   input  logic signed [8:0]    cos_q,
   iru_coord_gen_if.master      beat,
   output logic                 busy,
   output logic                 angle_err
);
   localparam int COEF_W = 9;
   localparam int ACC_W  = 13;
   localparam int CRD_W  = 6;

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t                   state;
   logic [35:0]              ang_r;
   logic signed [COEF_W-1:0] s_r;
   logic signed [COEF_W-1:0] c_r;
   logic [4:0]               r;
   logic [4:0]               c;
   logic                     rem;
   logic                     ang_ok;
   logic signed [ACC_W-1:0]  xc;
   logic signed [ACC_W-1:0]  yc;
   logic signed [ACC_W-1:0]  s13;
   logic signed [ACC_W-1:0]  c13;
   logic signed [CRD_W-1:0]  nx;
   logic signed [CRD_W-1:0]  ny;
   logic                     n_inb;

   // Floor shift back to pixel units and re-centre; -10..30 fits 6-bit signed exactly.
   function automatic logic signed [CRD_W-1:0] to_src(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
      logic signed [ACC_W-1:0] t;
      t = ((a + b) >>> 7) + 13'sd10;
      return t[CRD_W-1:0];
   endfunction

   assign ang_ok = (angle != '0) && ((angle & (angle - 36'd1)) == '0);

   // Cosine is the sine LUT read 90 degrees (nine 10-degree steps) ahead.
   assign sin_d = busy ? ang_r : '0;
   assign cos_d = busy ? {ang_r[8:0], ang_r[35:9]} : '0;

   assign xc  = $signed({8'd0, c}) - 13'sd10;
   assign yc  = $signed({8'd0, r}) - 13'sd10;
   assign s13 = $signed({{(ACC_W-COEF_W){s_r[COEF_W-1]}}, s_r});
   assign c13 = $signed({{(ACC_W-COEF_W){c_r[COEF_W-1]}}, c_r});

   assign nx    = to_src(xc * c13, -(yc * s13));
   assign ny    = to_src(xc * s13, yc * c13);
   assign n_inb = (nx >= 6'sd0) && (nx <= 6'sd19) && (ny >= 6'sd0) && (ny <= 6'sd19);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         ang_r          <= '0;
         s_r            <= '0;
         c_r            <= '0;
         r              <= '0;
         c              <= '0;
         rem            <= 1'b0;
         busy           <= 1'b0;
         angle_err      <= 1'b0;
         beat.out_valid <= 1'b0;
         beat.out_src_x <= '0;
         beat.out_src_y <= '0;
         beat.out_inb   <= 1'b0;
         beat.out_last  <= 1'b0;
      end else begin
         angle_err <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (ang_ok) begin
                     ang_r <= angle;
                     state <= LOAD;
                     busy  <= 1'b1;
                  end else begin
                     angle_err <= 1'b1;
                  end
               end
            end
            LOAD: begin
               s_r   <= sin_q;
               c_r   <= cos_q;
               r     <= '0;
               c     <= '0;
               rem   <= 1'b1;
               state <= RUN;
            end
            RUN: begin
               // A new beat may replace the current one only once it has been taken.
               if (rem && (!beat.out_valid || beat.out_ready)) begin
                  beat.out_valid <= 1'b1;
                  beat.out_src_x <= nx;
                  beat.out_src_y <= ny;
                  beat.out_inb   <= n_inb;
                  beat.out_last  <= (r == 5'd19) && (c == 5'd19);
                  if (c == 5'd19) begin
                     c <= '0;
                     if (r == 5'd19) begin
                        r   <= '0;
                        rem <= 1'b0;
                     end else begin
                        r <= r + 5'd1;
                     end
                  end else begin
                     c <= c + 5'd1;
                  end
               end else if (beat.out_ready) begin
                  beat.out_valid <= 1'b0;
                  if (beat.out_valid && beat.out_last) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_iru_coord_gen.sv
// Bench for iru_coord_gen: sine LUT model plus a raster-order reference of the
// rotated source coordinates, compared beat by beat at the consumer side.
module tb_iru_coord_gen;
   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [35:0]       angle = '0;
   logic [35:0]       sin_d;
   logic [35:0]       cos_d;
   logic signed [8:0] sin_q;
   logic signed [8:0] cos_q;
   logic              busy;
   logic              angle_err;

   int checks = 0;
   int failures = 0;
   int ex_x[400], ex_y[400], ex_inb[400], ex_last[400];
   int got_x[400], got_y[400], got_inb[400];
   int n;

   iru_coord_gen_if bus();

   iru_coord_gen dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .angle     (angle),
      .sin_d     (sin_d),
      .cos_d     (cos_d),
      .sin_q     (sin_q),
      .cos_q     (cos_q),
      .beat      (bus),
      .busy      (busy),
      .angle_err (angle_err)
   );

   always #5 clk = ~clk;

   // 128*sin(k*10 deg), rounded.
   function automatic int sin128(input int k);
      int m, a, q;
      m = k % 36;
      if (m <= 9) a = m;
      else if (m <= 18) a = 18 - m;
      else if (m <= 27) a = m - 18;
      else a = 36 - m;
      case (a)
         0: q = 0;   1: q = 22;  2: q = 44;  3: q = 64;  4: q = 82;
         5: q = 98;  6: q = 111; 7: q = 120; 8: q = 126;
         default: q = 128;
      endcase
      return (m > 18) ? -q : q;
   endfunction

   function automatic int fdiv128(input int v);
      return (v >= 0) ? v / 128 : -((-v + 127) / 128);
   endfunction

   always_comb begin
      sin_q = '0;
      cos_q = '0;
      for (int i = 0; i < 36; i++) begin
         if (sin_d[i]) sin_q = 9'(sin128(35 - i));
         if (cos_d[i]) cos_q = 9'(sin128(35 - i));
      end
   end

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic build(input int k);
      int s, co, xc, yc, i;
      s  = sin128(k);
      co = sin128(k + 9);
      i  = 0;
      for (int rr = 0; rr < 20; rr++) begin
         for (int cc = 0; cc < 20; cc++) begin
            xc = cc - 10;
            yc = rr - 10;
            ex_x[i]    = fdiv128(xc * co - yc * s) + 10;
            ex_y[i]    = fdiv128(xc * s + yc * co) + 10;
            ex_inb[i]  = (ex_x[i] >= 0 && ex_x[i] <= 19 && ex_y[i] >= 0 && ex_y[i] <= 19) ? 1 : 0;
            ex_last[i] = (i == 399) ? 1 : 0;
            i++;
         end
      end
   endtask

   // mode 0: ready held high; 1: random ready plus start pokes while busy; 2: reset after 150 beats
   task automatic run_sweep(input string pfx, input int k, input int mode, output int cnt);
      logic [35:0] ecos;
      int idx, cyc;
      logic was_stall;
      build(k);
      ecos = '0;
      ecos[35 - ((k + 9) % 36)] = 1'b1;
      @(negedge clk);
      angle = '0;
      angle[35 - k] = 1'b1;
      start = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({pfx, "_busy_load"}, busy, 1);
      chk({pfx, "_valid_load"}, bus.out_valid, 0);
      chk({pfx, "_sin_d"}, sin_d, angle);
      chk({pfx, "_cos_d"}, cos_d, ecos);
      @(negedge clk);
      chk({pfx, "_valid_run"}, bus.out_valid, 0);
      @(negedge clk);
      chk({pfx, "_valid_first"}, bus.out_valid, 1);
      idx = 0;
      cyc = 0;
      was_stall = 1'b0;
      while (idx < 400 && cyc < 4000) begin
         if (mode == 1) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            start = ($urandom_range(0, 7) == 0);
            angle = 36'd1 << $urandom_range(0, 35);
         end
         if (mode == 0 || was_stall)
            chk($sformatf("%s_valid_b%0d", pfx, idx), bus.out_valid, 1);
         if (bus.out_valid) begin
            chk($sformatf("%s_x_b%0d", pfx, idx), $signed(bus.out_src_x), ex_x[idx]);
            chk($sformatf("%s_y_b%0d", pfx, idx), $signed(bus.out_src_y), ex_y[idx]);
            chk($sformatf("%s_inb_b%0d", pfx, idx), bus.out_inb, ex_inb[idx]);
            chk($sformatf("%s_last_b%0d", pfx, idx), bus.out_last, ex_last[idx]);
            if (bus.out_ready) begin
               got_x[idx]   = $signed(bus.out_src_x);
               got_y[idx]   = $signed(bus.out_src_y);
               got_inb[idx] = int'(bus.out_inb);
               idx++;
            end
         end
         was_stall = bus.out_valid && !bus.out_ready;
         if (mode == 2 && idx == 150) begin
            cnt = idx;
            rst_n = 1'b0;
            #1;
            chk({pfx, "_rst_valid"}, bus.out_valid, 0);
            chk({pfx, "_rst_busy"}, busy, 0);
            chk({pfx, "_rst_x"}, bus.out_src_x, 0);
            chk({pfx, "_rst_last"}, bus.out_last, 0);
            chk({pfx, "_rst_sin_d"}, sin_d, 0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (5) begin
               @(negedge clk);
               chk({pfx, "_post_rst_valid"}, bus.out_valid, 0);
               chk({pfx, "_post_rst_busy"}, busy, 0);
            end
            return;
         end
         if (idx < 400) begin
            @(negedge clk);
            cyc++;
         end
      end
      cnt = idx;
      start = 1'b0;
      @(negedge clk);
      chk({pfx, "_busy_after"}, busy, 0);
      chk({pfx, "_valid_after"}, bus.out_valid, 0);
   endtask

   initial begin
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_x", bus.out_src_x, 0);
      chk("rst_y", bus.out_src_y, 0);
      chk("rst_inb", bus.out_inb, 0);
      chk("rst_last", bus.out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", angle_err, 0);
      chk("rst_sin_d", sin_d, 0);
      chk("rst_cos_d", cos_d, 0);
      rst_n = 1'b1;

      run_sweep("a0", 0, 0, n);
      chk("a0_count", n, 400);
      chk("a0_b399_x", got_x[399], 19);
      chk("a0_b399_y", got_y[399], 19);

      run_sweep("a90", 9, 1, n);
      chk("a90_count", n, 400);
      chk("a90_b0_x", got_x[0], 20);
      chk("a90_b0_y", got_y[0], 0);
      chk("a90_b0_inb", got_inb[0], 0);
      chk("a90_b21_x", got_x[21], 19);
      chk("a90_b21_y", got_y[21], 1);
      chk("a90_b21_inb", got_inb[21], 1);

      run_sweep("a10", 1, 0, n);
      chk("a10_count", n, 400);
      chk("a10_b0_x", got_x[0], 1);
      chk("a10_b0_y", got_y[0], -2);
      chk("a10_b0_inb", got_inb[0], 0);

      run_sweep("arnd", int'($urandom_range(0, 35)), 1, n);
      chk("arnd_count", n, 400);

      for (int t = 0; t < 2; t++) begin
         @(negedge clk);
         angle = (t == 0) ? 36'd0 : ((36'd1 << 35) | (36'd1 << 30));
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         chk($sformatf("err%0d_pulse", t), angle_err, 1);
         chk($sformatf("err%0d_busy", t), busy, 0);
         repeat (3) begin
            @(negedge clk);
            chk($sformatf("err%0d_pulse_end", t), angle_err, 0);
            chk($sformatf("err%0d_idle", t), busy, 0);
            chk($sformatf("err%0d_nobeat", t), bus.out_valid, 0);
         end
      end

      run_sweep("abort", 0, 2, n);
      chk("abort_count", n, 150);

      run_sweep("a180", 18, 0, n);
      chk("a180_count", n, 400);
      chk("a180_b0_x", got_x[0], 20);
      chk("a180_b0_y", got_y[0], 20);
      chk("a180_b0_inb", got_inb[0], 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
